// File: rtl/lzc_pipe.sv
// Pipelined leading-zero/one counter with valid/ready handshake and 1 or 2 register stages.
// Define LZC_TRAILING_EN to let in_mode[1] bit-reverse the operand for trailing counts.
module lzc_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1,
  localparam int unsigned CW     = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_all
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned HW = $clog2(H) + 1;

  logic [WIDTH-1:0] inv;
  logic [WIDTH-1:0] cond;

  assign inv = in_mode[0] ? ~in_data : in_data;

`ifdef LZC_TRAILING_EN
  logic [WIDTH-1:0] rev;
  always_comb begin
    for (int i = 0; i < WIDTH; i++) rev[i] = inv[WIDTH-1-i];
  end
  assign cond = in_mode[1] ? rev : inv;
`else
  logic unused_mode;
  assign unused_mode = in_mode[1];
  assign cond        = inv;
`endif

  // Highest set bit wins because the scan runs upward.
  function automatic logic [CW-1:0] clz_full(input logic [WIDTH-1:0] v);
    clz_full = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) if (v[i]) clz_full = CW'(WIDTH - 1 - i);
  endfunction

  function automatic logic [HW-1:0] clz_half(input logic [H-1:0] v);
    clz_half = HW'(H);
    for (int i = 0; i < H; i++) if (v[i]) clz_half = HW'(H - 1 - i);
  endfunction

  if (LATENCY == 1) begin : g_lat1
    logic          v_q;
    logic [CW-1:0] count_q;
    logic          all_q;
    logic          load;

    assign load = ~v_q | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q     <= 1'b0;
        count_q <= '0;
        all_q   <= 1'b0;
      end else if (load) begin
        v_q <= in_valid;
        if (in_valid) begin
          count_q <= clz_full(cond);
          all_q   <= (cond == '0);
        end
      end
    end

    assign in_ready  = load;
    assign out_valid = v_q;
    assign out_count = count_q;
    assign out_all   = all_q;
  end else if (LATENCY == 2) begin : g_lat2
    logic          s1_v_q;
    logic [HW-1:0] cnt_hi_q;
    logic [HW-1:0] cnt_lo_q;
    logic          z_hi_q;
    logic          z_lo_q;
    logic          s2_v_q;
    logic [CW-1:0] count_q;
    logic          all_q;
    logic          load1;
    logic          load2;

    assign load2 = ~s2_v_q | out_ready;
    assign load1 = ~s1_v_q | load2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_v_q   <= 1'b0;
        cnt_hi_q <= '0;
        cnt_lo_q <= '0;
        z_hi_q   <= 1'b0;
        z_lo_q   <= 1'b0;
      end else if (load1) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          cnt_hi_q <= clz_half(cond[WIDTH-1:H]);
          cnt_lo_q <= clz_half(cond[H-1:0]);
          z_hi_q   <= (cond[WIDTH-1:H] == '0);
          z_lo_q   <= (cond[H-1:0] == '0);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_v_q  <= 1'b0;
        count_q <= '0;
        all_q   <= 1'b0;
      end else if (load2) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          count_q <= z_hi_q ? CW'(H) + CW'(cnt_lo_q) : CW'(cnt_hi_q);
          all_q   <= z_hi_q & z_lo_q;
        end
      end
    end

    assign in_ready  = load1;
    assign out_valid = s2_v_q;
    assign out_count = count_q;
    assign out_all   = all_q;
  end else begin : g_bad
    $error("lzc_pipe: LATENCY must be 1 or 2");
  end

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed bench for lzc_pipe: one LATENCY=1 and one LATENCY=2 instance, WIDTH=32.
module tb_lzc_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_all;
  logic [31:0] a_in_data;
  logic [1:0]  a_in_mode;
  logic [5:0]  a_out_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_all;
  logic [31:0] b_in_data;
  logic [1:0]  b_in_mode;
  logic [5:0]  b_out_count;
  logic [31:0] b_exp;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [31:0] sb_q[$];

  lzc_pipe #(.WIDTH(32), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
    .out_all(a_out_all)
  );

  lzc_pipe #(.WIDTH(32), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
    .out_all(b_out_all)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int cnt);
    return 32'(cnt) | ((cnt == 32) ? 32'h40 : 32'h0);
  endfunction

  // Expected results for the LATENCY=2 instance travel through this queue in handshake order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_in_valid && b_in_ready) sb_q.push_back(b_exp);
      if (b_out_valid && b_out_ready) begin
        if (sb_q.size() == 0) check("b_spurious", 1, 0);
        else check("b_out", {25'd0, b_out_all, b_out_count}, sb_q.pop_front());
        n_out++;
      end
    end
  end

  task automatic a_vec(input logic [31:0] d, input logic [1:0] m, input int cnt, input string tag);
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = d; a_in_mode = m; a_out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_rdy"}, a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_vld"}, a_out_valid, 1);
    check(tag, a_out_count, cnt);
    check({tag, "_all"}, a_out_all, (cnt == 32));
  endtask

  logic [31:0] ops [6] = '{32'h0010_0000, 32'h0000_0001, 32'h0F00_0000,
                           32'hFFFF_0000, 32'h7FFF_FFFF, 32'h0000_0003};
  logic [1:0]  mds [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
  int          cnts[6] = '{11, 31, 4, 16, 0, 30};

  initial begin
    int n0, gaps, rdy_miss, k, stale;
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_in_mode = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_in_mode = 0; b_out_ready = 0; b_exp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_vld", a_out_valid, 0);
    check("rst_a_cnt", a_out_count, 0);
    check("rst_a_all", a_out_all, 0);
    check("rst_b_vld", b_out_valid, 0);
    check("rst_b_cnt", b_out_count, 0);
    check("rst_b_all", b_out_all, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LATENCY=1 single transfers, including the boundary operands.
    a_vec(32'h0001_0000, 2'b00, 15, "l1_x10000");
    a_vec(32'h0000_0000, 2'b00, 32, "l1_zero");
    a_vec(32'hFFFF_FFFF, 2'b01, 32, "l1_ones");
    a_vec(32'h8000_0000, 2'b00, 0,  "l1_msb");
    a_vec(32'hF000_0000, 2'b01, 4,  "l1_clo4");
`ifdef LZC_TRAILING_EN
    a_vec(32'h0000_0100, 2'b10, 8,  "l1_tz");
    a_vec(32'h0000_00FF, 2'b11, 8,  "l1_to");
`else
    a_vec(32'h0000_0100, 2'b10, 23, "l1_tz_off");
    a_vec(32'h0000_00FF, 2'b11, 0,  "l1_to_off");
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("l1_drain", a_out_valid, 0);

    // LATENCY=2 full-throughput stream of walking ones.
    b_out_ready = 1'b1; gaps = 0; rdy_miss = 0; n0 = n_out;
    for (int c = 0; c < 34; c++) begin
      @(posedge clk); #1;
      if (c < 32) begin
        b_in_valid = 1'b1; b_in_data = 32'h1 << c; b_in_mode = 2'b00; b_exp = exp_word(31 - c);
      end else b_in_valid = 1'b0;
      @(negedge clk);
      if (c < 32 && !b_in_ready) rdy_miss++;
      if (c >= 2 && !b_out_valid) gaps++;
    end
    @(posedge clk); #1;
    check("l2_stream_n", n_out - n0, 32);
    check("l2_stream_gaps", gaps, 0);
    check("l2_stream_rdy", rdy_miss, 0);

    // LATENCY=2 stall with in_valid held, then release.
    k = 0; n0 = n_out;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      b_out_ready = (c >= 5);
      if (k < 6) begin
        b_in_valid = 1'b1; b_in_data = ops[k]; b_in_mode = mds[k]; b_exp = exp_word(cnts[k]);
      end else b_in_valid = 1'b0;
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        check("stall_vld", b_out_valid, 1);
        check("stall_cnt", b_out_count, 11);
      end
      if (c == 4) begin
        check("stall_acc", k, 2);
        check("stall_rdy", b_in_ready, 0);
      end
      if (b_in_valid && b_in_ready) k++;
    end
    @(posedge clk); #1;
    check("stall_n", n_out - n0, 6);
    check("stall_sb_empty", sb_q.size(), 0);

    // Reset with two operands in flight.
    b_out_ready = 1'b0;
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_data = 32'h0000_1000; b_in_mode = 2'b00; b_exp = exp_word(19);
    @(posedge clk); #1;
    b_in_data = 32'h0000_0010; b_exp = exp_word(27);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    check("inflight_vld", b_out_valid, 1);
    check("inflight_cnt", b_out_count, 19);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_vld", b_out_valid, 0);
    check("midrst_cnt", b_out_count, 0);
    check("midrst_all", b_out_all, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; b_out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (b_out_valid) stale++;
    end
    check("post_rst_stale", stale, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
